// File: rtl/qn_fifo_pkg.sv
// qn_fifo_pkg: shared sizing, source tags and read-FSM encoding for the FIFO share controller.
package qn_fifo_pkg;
  localparam int DEPTH = 128;
  localparam int OCC_W = 8;
  localparam logic TAG_A = 1'b0;
  localparam logic TAG_B = 1'b1;
  typedef enum logic [1:0] {IDLE, RD, WAIT, HOLD} rd_state_e;
endpackage

// File: rtl/fifo_share_ctrl_if.sv
// fifo_share_ctrl_if: source, FIFO and consumer signals of the share controller.
interface fifo_share_ctrl_if #(parameter int OCC_W = qn_fifo_pkg::OCC_W);
  logic REQ_A, REQ_B, ACK_A, ACK_B;
  logic [14:0] DATA_A, DATA_B;
  logic FIFO_WR_EN, FIFO_FULL, FIFO_RD_EN, FIFO_VALID, FIFO_EMPTY;
  logic [15:0] FIFO_DIN, FIFO_DOUT, DATA_OUT;
  logic DATAREADY, DATA_ACK, RD_ERR;
  logic [OCC_W-1:0] OCC;
  logic [7:0] LED;
  modport master (
    input REQ_A, REQ_B, DATA_A, DATA_B, FIFO_FULL, FIFO_DOUT, FIFO_VALID, FIFO_EMPTY, DATA_ACK,
    output ACK_A, ACK_B, FIFO_WR_EN, FIFO_DIN, FIFO_RD_EN, DATA_OUT, DATAREADY, OCC, LED, RD_ERR
  );
  modport slave (
    output REQ_A, REQ_B, DATA_A, DATA_B, FIFO_FULL, FIFO_DOUT, FIFO_VALID, FIFO_EMPTY, DATA_ACK,
    input ACK_A, ACK_B, FIFO_WR_EN, FIFO_DIN, FIFO_RD_EN, DATA_OUT, DATAREADY, OCC, LED, RD_ERR
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin arbiter with per-request masks and a global enable.
module rr_arb2 (
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic mask_a_i,
  input  logic mask_b_i,
  input  logic en_i,
  input  logic ptr_i,
  output logic grant_a_o,
  output logic grant_b_o,
  output logic ptr_o
);
  import qn_fifo_pkg::*;
  logic elig_a, elig_b;
  assign elig_a = en_i && req_a_i && !mask_a_i;
  assign elig_b = en_i && req_b_i && !mask_b_i;
  assign grant_a_o = elig_a && (!elig_b || ptr_i == TAG_A);
  assign grant_b_o = elig_b && (!elig_a || ptr_i == TAG_B);
  assign ptr_o = grant_a_o ? TAG_B : grant_b_o ? TAG_A : ptr_i;
endmodule

// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: arbitrates two sources onto one FIFO and hands words to a consumer one at a time.
module fifo_share_ctrl #(
  parameter int DEPTH = qn_fifo_pkg::DEPTH,
  parameter int OCC_W = qn_fifo_pkg::OCC_W
) (
  input logic clk100,
  input logic RST_N,
  fifo_share_ctrl_if.master bus
);
  import qn_fifo_pkg::*;
  logic ack_a_q, ack_b_q, wr_en_q, ptr_q, ptr_d, grant_a, grant_b, wr_ok, rd_en, rd_err_q, rd_err_d;
  logic [15:0] din_q, din_d, dout_q, dout_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W:0] occ_nxt;
  logic [7:0] led_q, led_d;
  rd_state_e state_q, state_d;
  // Only the write already committed counts; a read in flight earns no credit.
  assign occ_nxt = {1'b0, occ_q} + (OCC_W+1)'(wr_en_q);
  assign wr_ok = occ_nxt < (OCC_W+1)'(DEPTH) && !bus.FIFO_FULL;
  rr_arb2 u_arb (
    .req_a_i  (bus.REQ_A),
    .req_b_i  (bus.REQ_B),
    .mask_a_i (ack_a_q),
    .mask_b_i (ack_b_q),
    .en_i     (wr_ok),
    .ptr_i    (ptr_q),
    .grant_a_o(grant_a),
    .grant_b_o(grant_b),
    .ptr_o    (ptr_d)
  );
  always_ff @(posedge clk100 or negedge RST_N)
    if (!RST_N) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (occ_q != '0 && !bus.FIFO_EMPTY) ? RD : IDLE;
      RD:      state_d = WAIT;
      WAIT:    state_d = bus.FIFO_VALID ? HOLD : IDLE;
      HOLD:    state_d = bus.DATA_ACK ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rd_en = state_q == RD;
    dout_d = (state_q == WAIT && bus.FIFO_VALID) ? bus.FIFO_DOUT : dout_q;
    rd_err_d = rd_err_q || (state_q == WAIT && !bus.FIFO_VALID);
    led_d = led_q + 8'(state_q == HOLD && bus.DATA_ACK);
    din_d = grant_b ? {TAG_B, bus.DATA_B} : grant_a ? {TAG_A, bus.DATA_A} : din_q;
    occ_d = occ_q + OCC_W'(wr_en_q) - OCC_W'(rd_en);
  end
  always_ff @(posedge clk100 or negedge RST_N)
    if (!RST_N) begin
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      din_q    <= '0;
      ptr_q    <= TAG_A;
      occ_q    <= '0;
      dout_q   <= '0;
      led_q    <= '0;
      rd_err_q <= 1'b0;
    end else begin
      ack_a_q  <= grant_a;
      ack_b_q  <= grant_b;
      wr_en_q  <= grant_a || grant_b;
      din_q    <= din_d;
      ptr_q    <= ptr_d;
      occ_q    <= occ_d;
      dout_q   <= dout_d;
      led_q    <= led_d;
      rd_err_q <= rd_err_d;
    end
  assign bus.ACK_A = ack_a_q;
  assign bus.ACK_B = ack_b_q;
  assign bus.FIFO_WR_EN = wr_en_q;
  assign bus.FIFO_DIN = din_q;
  assign bus.FIFO_RD_EN = rd_en;
  assign bus.DATA_OUT = dout_q;
  assign bus.DATAREADY = state_q == HOLD;
  assign bus.OCC = occ_q;
  assign bus.LED = led_q;
  assign bus.RD_ERR = rd_err_q;
endmodule

// File: tb/tb_fifo_share_ctrl.sv
// tb_fifo_share_ctrl: directed bench with a behavioural FIFO for fifo_share_ctrl.
module tb_fifo_share_ctrl;
  logic clk100 = 1'b0;
  logic RST_N = 1'b0;
  always #5 clk100 = ~clk100;
  fifo_share_ctrl_if #(.OCC_W(8)) bus();
  fifo_share_ctrl dut (.clk100(clk100), .RST_N(RST_N), .bus(bus.master));
  int tests = 0;
  int failed = 0;
  logic [15:0] q[$];
  int level, wr_cnt, del_cnt;
  logic [15:0] dout_r;
  logic vld_r, hold_empty, drop_valid;
  assign bus.FIFO_DOUT = dout_r;
  assign bus.FIFO_VALID = vld_r;
  assign bus.FIFO_EMPTY = level == 0 || hold_empty;
  assign bus.FIFO_FULL = level >= 128;
  // FIFO model: read data and VALID appear the cycle after RD_EN; drop_valid loses the word.
  always @(posedge clk100 or negedge RST_N)
    if (!RST_N) begin
      q.delete();
      level <= 0;
      wr_cnt <= 0;
      del_cnt <= 0;
      vld_r <= 1'b0;
      dout_r <= '0;
    end else begin
      vld_r <= 1'b0;
      if (bus.FIFO_RD_EN && q.size() > 0) begin
        dout_r <= q.pop_front();
        vld_r <= !drop_valid;
      end
      if (bus.FIFO_WR_EN) begin
        q.push_back(bus.FIFO_DIN);
        wr_cnt <= wr_cnt + 1;
      end
      if (bus.DATAREADY && bus.DATA_ACK) del_cnt <= del_cnt + 1;
      level <= q.size();
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk100);
  endtask
  task automatic do_reset();
    RST_N = 1'b0;
    bus.REQ_A = 1'b0;
    bus.REQ_B = 1'b0;
    bus.DATA_ACK = 1'b0;
    cyc(2);
  endtask
  task automatic write_word(input logic src, input logic [14:0] d);
    int n = 0;
    if (src) begin bus.DATA_B = d; bus.REQ_B = 1'b1; end
    else begin bus.DATA_A = d; bus.REQ_A = 1'b1; end
    do begin cyc(1); n++; end while (!(src ? bus.ACK_B : bus.ACK_A) && n < 20);
    chk(src ? "wr_ack_b" : "wr_ack_a", 32'(src ? bus.ACK_B : bus.ACK_A), 1);
    if (src) bus.REQ_B = 1'b0;
    else bus.REQ_A = 1'b0;
  endtask
  initial begin
    int n, n_ack;
    bus.REQ_A = 1'b0;
    bus.REQ_B = 1'b0;
    bus.DATA_A = '0;
    bus.DATA_B = '0;
    bus.DATA_ACK = 1'b0;
    hold_empty = 1'b0;
    drop_valid = 1'b0;
    cyc(2);
    chk("rst_flags", {26'd0, bus.ACK_A, bus.ACK_B, bus.FIFO_WR_EN, bus.FIFO_RD_EN, bus.DATAREADY, bus.RD_ERR}, 0);
    chk("rst_occ", bus.OCC, 0);
    chk("rst_led", bus.LED, 0);
    chk("rst_din", bus.FIFO_DIN, 0);
    chk("rst_dout", bus.DATA_OUT, 0);
    // single source, reader parked so occupancy accumulates
    hold_empty = 1'b1;
    bus.DATA_A = 15'h1234;
    bus.REQ_A = 1'b1;
    RST_N = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      chk($sformatf("single_ack_a_c%0d", i), bus.ACK_A, i % 2);
      if (i % 2 == 1) chk($sformatf("single_din_c%0d", i), bus.FIFO_DIN, 16'h1234);
      if (i == 5) bus.REQ_A = 1'b0;
    end
    cyc(1);
    chk("single_occ", bus.OCC, 3);
    chk("single_no_ack", bus.ACK_A, 0);
    // contention, then fill to DEPTH
    do_reset();
    bus.DATA_A = 15'h0111;
    bus.DATA_B = 15'h0222;
    bus.REQ_A = 1'b1;
    bus.REQ_B = 1'b1;
    RST_N = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      chk($sformatf("cont_ack_a_c%0d", i), bus.ACK_A, i % 2);
      chk($sformatf("cont_ack_b_c%0d", i), bus.ACK_B, (i + 1) % 2);
      chk($sformatf("cont_din_c%0d", i), bus.FIFO_DIN, (i % 2 == 1) ? 16'h0111 : 16'h8222);
    end
    n = 0;
    while (bus.OCC != 8'd128 && n < 400) begin cyc(1); n++; end
    chk("full_occ", bus.OCC, 128);
    chk("full_writes", wr_cnt, 128);
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_ack += int'(bus.ACK_A | bus.ACK_B);
    end
    chk("full_no_ack", n_ack, 0);
    chk("full_occ_hold", bus.OCC, 128);
    hold_empty = 1'b0;
    cyc(12);
    chk("full_one_more_write", wr_cnt, 129);
    chk("full_occ_refill", bus.OCC, 128);
    chk("full_ready", bus.DATAREADY, 1);
    chk("full_dout_first", bus.DATA_OUT, 16'h0111);
    bus.DATA_ACK = 1'b1;
    cyc(1);
    bus.DATA_ACK = 1'b0;
    chk("full_ready_drop", bus.DATAREADY, 0);
    chk("full_led", bus.LED, 1);
    cyc(12);
    chk("full_slot_write", wr_cnt, 130);
    chk("full_occ_again", bus.OCC, 128);
    chk("full_ready2", bus.DATAREADY, 1);
    chk("full_dout_second", bus.DATA_OUT, 16'h8222);
    // readout latency and LED wrap
    do_reset();
    bus.REQ_A = 1'b0;
    bus.DATA_B = 15'h0005;
    bus.REQ_B = 1'b1;
    RST_N = 1'b1;
    cyc(1);
    chk("rd_ack_b", bus.ACK_B, 1);
    bus.REQ_B = 1'b0;
    cyc(1);
    chk("rd_occ1", bus.OCC, 1);
    chk("rd_en_c2", bus.FIFO_RD_EN, 0);
    cyc(1);
    chk("rd_en_c3", bus.FIFO_RD_EN, 1);
    chk("rd_ready_c3", bus.DATAREADY, 0);
    cyc(1);
    chk("rd_en_c4", bus.FIFO_RD_EN, 0);
    chk("rd_ready_c4", bus.DATAREADY, 0);
    cyc(1);
    chk("rd_ready_c5", bus.DATAREADY, 1);
    chk("rd_dout", bus.DATA_OUT, 16'h8005);
    chk("rd_occ0", bus.OCC, 0);
    bus.DATA_ACK = 1'b1;
    cyc(1);
    chk("rd_ready_c6", bus.DATAREADY, 0);
    chk("rd_led1", bus.LED, 1);
    bus.DATA_A = 15'h0042;
    bus.REQ_A = 1'b1;
    n = 0;
    while (del_cnt < 256 && n < 3000) begin cyc(1); n++; end
    chk("wrap_deliveries", del_cnt, 256);
    chk("wrap_led", bus.LED, 0);
    bus.REQ_A = 1'b0;
    bus.DATA_ACK = 1'b0;
    // read error: VALID withheld after a read
    do_reset();
    drop_valid = 1'b1;
    RST_N = 1'b1;
    write_word(1'b0, 15'h0055);
    cyc(4);
    chk("err_flag", bus.RD_ERR, 1);
    chk("err_ready", bus.DATAREADY, 0);
    chk("err_dout", bus.DATA_OUT, 0);
    chk("err_occ", bus.OCC, 0);
    drop_valid = 1'b0;
    write_word(1'b0, 15'h0066);
    n = 0;
    while (!bus.DATAREADY && n < 20) begin cyc(1); n++; end
    chk("err_next_ready", bus.DATAREADY, 1);
    chk("err_next_dout", bus.DATA_OUT, 16'h0066);
    chk("err_sticky", bus.RD_ERR, 1);
    // asynchronous reset while holding a word with OCC = 5
    do_reset();
    RST_N = 1'b1;
    for (int i = 0; i < 7; i++) write_word(1'b0, 15'h0100 + 15'(i));
    cyc(5);
    bus.DATA_ACK = 1'b1;
    cyc(1);
    bus.DATA_ACK = 1'b0;
    cyc(6);
    chk("mid_occ5", bus.OCC, 5);
    chk("mid_hold", bus.DATAREADY, 1);
    chk("mid_led1", bus.LED, 1);
    #2;
    RST_N = 1'b0;
    bus.DATA_A = 15'h0777;
    bus.DATA_B = 15'h0333;
    bus.REQ_A = 1'b1;
    bus.REQ_B = 1'b1;
    #1;
    chk("async_ready", bus.DATAREADY, 0);
    chk("async_occ", bus.OCC, 0);
    chk("async_led", bus.LED, 0);
    chk("async_acks", {30'd0, bus.ACK_A, bus.ACK_B}, 0);
    cyc(2);
    RST_N = 1'b1;
    cyc(1);
    chk("restart_ack_a", bus.ACK_A, 1);
    chk("restart_ack_b", bus.ACK_B, 0);
    chk("restart_din", bus.FIFO_DIN, 16'h0777);
    cyc(1);
    chk("restart_then_b", bus.ACK_B, 1);
    chk("restart_din_b", bus.FIFO_DIN, 16'h8333);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
